// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction fetch front end. Holds the PC, issues word reads
//               to a synchronous imem (data one cycle after request), buffers
//               returned words in a small FIFO and hands them to decode via a
//               valid/ready handshake. External redirects flush the FIFO and
//               kill any response that is returning.
//               Optional macro PREDECODE_JUMP_EN: returning 'j' words
//               self-redirect the fetch PC as they are pushed.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);

  typedef logic [c_ptr_w-1:0] ptr_t;
  typedef logic [c_cnt_w-1:0] cnt_t;
  typedef logic [c_cnt_w:0]   occ_t;

  // Architectural state
  logic [31:0] pc_q, pc_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  cnt_t        cnt_q, cnt_d;
  logic        inflight_q;
  logic [31:0] inflight_pc_q;
  logic        killed_q;
  logic [31:0] fifo_instr_q [FIFO_DEPTH];
  logic [31:0] fifo_pc_q    [FIFO_DEPTH];

  // Handshake / control wires
  logic        pop;
  logic        push;
  logic        issue;
  logic        jump;
  logic [31:0] jump_target;
  occ_t        occ;
  ptr_t        head_idx;

  assign instr_valid = (cnt_q != '0);
  assign pop         = instr_valid & instr_ready;

  // A returning word is kept unless its fetch was killed or a redirect
  // flushes the stream in the very cycle it arrives.
  assign push = inflight_q & ~killed_q & ~redirect;

  // Occupancy credits the pop of this cycle so a full-rate stream keeps
  // one word buffered, one returning and one being issued with no bubbles.
  assign occ   = occ_t'(cnt_q) + occ_t'(inflight_q) - occ_t'(pop);
  assign issue = ~reset & ~redirect & (occ < occ_t'(FIFO_DEPTH));

  assign imem_req  = issue;
  assign imem_addr = pc_q;

  // When empty, show the most recently delivered entry so outputs hold steady.
  assign head_idx = (cnt_q == '0) ? (rd_ptr_q - ptr_t'(1)) : rd_ptr_q;
  assign instr    = fifo_instr_q[head_idx];
  assign instr_pc = fifo_pc_q[head_idx];

`ifdef PREDECODE_JUMP_EN
  logic [31:0] jump_pc4;
  assign jump_pc4    = inflight_pc_q + 32'd4;
  assign jump        = push & (imem_rdata[31:26] == 6'h02);
  assign jump_target = {jump_pc4[31:28], imem_rdata[25:0], 2'b00};
`else
  assign jump        = 1'b0;
  assign jump_target = 32'h0000_0000;
`endif

  // Next-state for PC (redirect > self-jump > sequential) and FIFO bookkeeping
  always_comb begin
    pc_d = pc_q;
    if (redirect)   pc_d = {redirect_pc[31:2], 2'b00};
    else if (jump)  pc_d = jump_target;
    else if (issue) pc_d = pc_q + 32'd4;

    rd_ptr_d = pop ? (rd_ptr_q + ptr_t'(1)) : rd_ptr_q;

    if (redirect) begin
      wr_ptr_d = rd_ptr_d;
      cnt_d    = '0;
    end else begin
      wr_ptr_d = push ? (wr_ptr_q + ptr_t'(1)) : wr_ptr_q;
      cnt_d    = cnt_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // State registers; the request issued alongside a self-jump is marked killed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      killed_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      inflight_q <= issue;
      killed_q   <= issue & jump;
      if (issue) inflight_pc_q <= pc_q;
      if (push) begin
        fifo_instr_q[wr_ptr_q] <= imem_rdata;
        fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
      end
    end
  end

endmodule
`default_nettype wire
